// File: rtl/plru_replace_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// plru_replace_pkg : shared constants, types and LFSR step for plru_replace
// Rev 1.0
// ----------------------------------------------------------------------------
package plru_replace_pkg;

  localparam logic        PLRU_MODE_TREE = 1'b0;
  localparam logic        PLRU_MODE_RAND = 1'b1;
  localparam logic [15:0] PLRU_LFSR_SEED = 16'hACE1;

  typedef enum logic [0:0] {
    FLUSH_IDLE  = 1'b0,
    FLUSH_SWEEP = 1'b1
  } flush_state_e;

  // 16-bit Fibonacci LFSR, taps 16/14/13/11, shifting toward bit 0
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/plru_replace_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// plru_replace_if : access, flush and victim-result signals of plru_replace
// Rev 1.0
// ----------------------------------------------------------------------------
interface plru_replace_if #(
  parameter int WAYS  = 4,
  parameter int SETS  = 64,
  parameter int IDX_W = $clog2(SETS),
  parameter int WAY_W = $clog2(WAYS)
);
  import plru_replace_pkg::*;

  logic             acc_valid;
  logic             acc_ready;
  logic [IDX_W-1:0] acc_index;
  logic [WAYS-1:0]  acc_hit;
  logic [WAYS-1:0]  acc_line_valid;
  logic [WAYS-1:0]  acc_lock;
  logic             repl_mode;
  logic             flush_req;
  logic             flush_busy;
  logic             victim_valid;
  logic [WAYS-1:0]  victim_way;
  logic [WAY_W-1:0] victim_id;
  logic             victim_none;

  modport master (
    output acc_valid, acc_index, acc_hit, acc_line_valid, acc_lock,
    output repl_mode, flush_req,
    input  acc_ready, flush_busy,
    input  victim_valid, victim_way, victim_id, victim_none
  );

  modport slave (
    input  acc_valid, acc_index, acc_hit, acc_line_valid, acc_lock,
    input  repl_mode, flush_req,
    output acc_ready, flush_busy,
    output victim_valid, victim_way, victim_id, victim_none
  );

endinterface
`default_nettype wire

// File: rtl/plru_tree_walk.sv
`default_nettype none
// ----------------------------------------------------------------------------
// plru_tree_walk : lock-aware PLRU victim walk and touch update of one set
// Rev 1.0
// ----------------------------------------------------------------------------
module plru_tree_walk #(
  parameter int WAYS  = 4,
  parameter int WAY_W = $clog2(WAYS)
) (
  input  logic [WAYS-2:0]  tree,
  input  logic [WAYS-1:0]  lock,
  input  logic [WAY_W-1:0] touch_id,
  output logic [WAY_W-1:0] plru_id,
  output logic [WAYS-2:0]  tree_next
);
  import plru_replace_pkg::*;

  logic [WAYS-1:0]   heap;
  logic [2*WAYS-1:0] sub_locked;
  logic [WAY_W:0]    leaf_node;
  logic [WAY_W-1:0]  node;
  logic [WAY_W:0]    child;
  logic              dir;

  // Heap numbering: node n has children 2n/2n+1, leaves are WAYS+way
  assign heap      = {tree, 1'b0};
  assign leaf_node = {1'b1, touch_id};

  always_comb begin
    sub_locked                    = '0;
    sub_locked[2*WAYS-1:WAYS]     = lock;
    for (int n = WAYS - 1; n >= 1; n--) begin
      sub_locked[n] = sub_locked[2*n] & sub_locked[2*n+1];
    end
  end

  always_comb begin
    node  = WAY_W'(1);
    child = '0;
    dir   = 1'b0;
    for (int l = 0; l < WAY_W; l++) begin
      dir   = heap[node];
      child = {node, dir};
      if (sub_locked[child]) begin
        child = {node, ~dir};
      end
      node = child[WAY_W-1:0];
    end
    plru_id = node;
  end

  for (genvar n = 1; n < WAYS; n++) begin : g_touch
    localparam int LVL = $clog2(n + 1) - 1;
    localparam int SH  = WAY_W - LVL;
    assign tree_next[n-1] = (leaf_node[WAY_W:SH] == (LVL + 1)'(n)) ? ~leaf_node[SH-1]
                                                                  : tree[n-1];
  end

endmodule
`default_nettype wire

// File: rtl/plru_replace.sv
`default_nettype none
// ----------------------------------------------------------------------------
// plru_replace : per-set tree-PLRU / LFSR replacement with locks and flush
// Rev 1.0
// ----------------------------------------------------------------------------
module plru_replace #(
  parameter int WAYS  = 4,
  parameter int SETS  = 64,
  parameter int IDX_W = $clog2(SETS),
  parameter int WAY_W = $clog2(WAYS)
) (
  input  logic          clk,
  input  logic          rst_n,
  plru_replace_if.slave bus
);
  import plru_replace_pkg::*;

  logic [WAYS-2:0]  tree_q [SETS];
  logic [15:0]      lfsr_q, lfsr_d;
  flush_state_e     state_q;
  logic [IDX_W-1:0] cnt_q;
  logic             flush_busy_q;
  logic             victim_valid_q, victim_valid_d;
  logic [WAYS-1:0]  victim_way_q, victim_way_d;
  logic [WAY_W-1:0] victim_id_q, victim_id_d;
  logic             victim_none_q, victim_none_d;

  logic             accept, is_hit, all_locked, has_free;
  logic [WAY_W-1:0] hit_id, free_id, rand_id, plru_id, sel_id, touch_id, cand;
  logic [WAYS-2:0]  tree_rd, tree_next, tree_wd;
  logic             tree_we;
  logic [IDX_W-1:0] tree_wa;

  assign bus.acc_ready    = !flush_busy_q && !bus.flush_req;
  assign bus.flush_busy   = flush_busy_q;
  assign bus.victim_valid = victim_valid_q;
  assign bus.victim_way   = victim_way_q;
  assign bus.victim_id    = victim_id_q;
  assign bus.victim_none  = victim_none_q;

  assign accept     = bus.acc_valid && bus.acc_ready;
  assign is_hit     = |bus.acc_hit;
  assign all_locked = &bus.acc_lock;
  assign tree_rd    = tree_q[bus.acc_index];

  // Descending scans leave the lowest qualifying index in each result
  always_comb begin
    hit_id   = '0;
    free_id  = '0;
    has_free = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (bus.acc_hit[w]) begin
        hit_id = WAY_W'(w);
      end
      if (!bus.acc_line_valid[w] && !bus.acc_lock[w]) begin
        free_id  = WAY_W'(w);
        has_free = 1'b1;
      end
    end
  end

  always_comb begin
    rand_id = lfsr_q[WAY_W-1:0];
    cand    = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      cand = lfsr_q[WAY_W-1:0] + WAY_W'(i);
      if (!bus.acc_lock[cand]) begin
        rand_id = cand;
      end
    end
  end

  assign sel_id   = has_free ? free_id
                  : (bus.repl_mode == PLRU_MODE_RAND) ? rand_id : plru_id;
  assign touch_id = is_hit ? hit_id : sel_id;

  plru_tree_walk #(.WAYS(WAYS), .WAY_W(WAY_W)) u_walk (
    .tree      (tree_rd),
    .lock      (bus.acc_lock),
    .touch_id  (touch_id),
    .plru_id   (plru_id),
    .tree_next (tree_next)
  );

  always_comb begin
    tree_we = 1'b0;
    tree_wa = bus.acc_index;
    tree_wd = tree_next;
    if (state_q == FLUSH_SWEEP) begin
      tree_we = 1'b1;
      tree_wa = cnt_q;
      tree_wd = '0;
    end else if (accept && (is_hit || !all_locked)) begin
      tree_we = 1'b1;
    end
  end

  always_comb begin
    lfsr_d         = lfsr_q;
    victim_valid_d = 1'b0;
    victim_way_d   = victim_way_q;
    victim_id_d    = victim_id_q;
    victim_none_d  = victim_none_q;
    if (accept && !is_hit) begin
      lfsr_d         = lfsr_step(lfsr_q);
      victim_valid_d = 1'b1;
      victim_none_d  = all_locked;
      victim_id_d    = all_locked ? '0 : sel_id;
      victim_way_d   = all_locked ? '0 : (WAYS'(1) << sel_id);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        tree_q[s] <= '0;
      end
      lfsr_q         <= PLRU_LFSR_SEED;
      victim_valid_q <= 1'b0;
      victim_way_q   <= '0;
      victim_id_q    <= '0;
      victim_none_q  <= 1'b0;
    end else begin
      if (tree_we) begin
        tree_q[tree_wa] <= tree_wd;
      end
      lfsr_q         <= lfsr_d;
      victim_valid_q <= victim_valid_d;
      victim_way_q   <= victim_way_d;
      victim_id_q    <= victim_id_d;
      victim_none_q  <= victim_none_d;
    end
  end

  // Flush sweep: one set cleared per cycle, new requests ignored while sweeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FLUSH_IDLE;
      cnt_q        <= '0;
      flush_busy_q <= 1'b0;
    end else begin
      case (state_q)
        FLUSH_IDLE: begin
          if (bus.flush_req) begin
            state_q      <= FLUSH_SWEEP;
            cnt_q        <= '0;
            flush_busy_q <= 1'b1;
          end
        end
        FLUSH_SWEEP: begin
          if (cnt_q == IDX_W'(SETS - 1)) begin
            state_q      <= FLUSH_IDLE;
            cnt_q        <= '0;
            flush_busy_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + IDX_W'(1);
          end
        end
        default: state_q <= FLUSH_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_plru_replace.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_plru_replace : directed self-checking bench for plru_replace (4 ways, 64 sets)
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_plru_replace;

  localparam int WAYS = 4;
  localparam int SETS = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   errors  = 0;
  int   busy_cycles;
  int   ready_bad;

  plru_replace_if #(.WAYS(WAYS), .SETS(SETS)) bus ();

  plru_replace #(.WAYS(WAYS), .SETS(SETS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] idx, input logic [3:0] hit,
                       input logic [3:0] lv, input logic [3:0] lock);
    @(negedge clk);
    bus.acc_valid      = v;
    bus.acc_index      = idx;
    bus.acc_hit        = hit;
    bus.acc_line_valid = lv;
    bus.acc_lock       = lock;
    @(posedge clk);
    #1;
  endtask

  task automatic check_victim(input string tag, input logic [1:0] id, input logic none);
    chk({tag, ".valid"}, 32'(bus.victim_valid), 32'd1);
    chk({tag, ".id"},    32'(bus.victim_id),    32'(id));
    chk({tag, ".way"},   32'(bus.victim_way),   none ? 32'd0 : 32'(4'b0001 << id));
    chk({tag, ".none"},  32'(bus.victim_none),  32'(none));
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n         = 1'b0;
    bus.acc_valid = 1'b0;
    bus.flush_req = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.acc_valid      = 1'b0;
    bus.acc_index      = '0;
    bus.acc_hit        = '0;
    bus.acc_line_valid = '0;
    bus.acc_lock       = '0;
    bus.repl_mode      = 1'b0;
    bus.flush_req      = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset.acc_ready",    32'(bus.acc_ready),    32'd1);
    chk("reset.flush_busy",   32'(bus.flush_busy),   32'd0);
    chk("reset.victim_valid", 32'(bus.victim_valid), 32'd0);
    chk("reset.victim_way",   32'(bus.victim_way),   32'd0);
    chk("reset.victim_id",    32'(bus.victim_id),    32'd0);
    chk("reset.victim_none",  32'(bus.victim_none),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // First free (invalid, unlocked) way wins
    drive(1'b1, 6'd0, 4'b0000, 4'b1011, 4'b0000);
    check_victim("free", 2'd2, 1'b0);
    drive(1'b0, 6'd0, 4'b0000, 4'b1111, 4'b0000);
    chk("pulse.one_cycle", 32'(bus.victim_valid), 32'd0);

    // Set 5: touch every way in order, then two back-to-back misses
    drive(1'b1, 6'd5, 4'b0001, 4'b1111, 4'b0000);
    chk("hit0.no_victim", 32'(bus.victim_valid), 32'd0);
    drive(1'b1, 6'd5, 4'b0010, 4'b1111, 4'b0000);
    drive(1'b1, 6'd5, 4'b0100, 4'b1111, 4'b0000);
    drive(1'b1, 6'd5, 4'b1000, 4'b1111, 4'b0000);
    chk("hit3.no_victim", 32'(bus.victim_valid), 32'd0);
    drive(1'b1, 6'd5, 4'b0000, 4'b1111, 4'b0000);
    check_victim("plru.first", 2'd0, 1'b0);
    drive(1'b1, 6'd5, 4'b0000, 4'b1111, 4'b0000);
    check_victim("plru.second", 2'd2, 1'b0);

    // Set 9: locked left half steers right; all locked yields none and no touch
    drive(1'b1, 6'd9, 4'b0000, 4'b1111, 4'b0011);
    check_victim("lock.steer", 2'd2, 1'b0);
    drive(1'b1, 6'd9, 4'b0000, 4'b1111, 4'b1111);
    check_victim("lock.all", 2'd0, 1'b1);
    drive(1'b1, 6'd9, 4'b0000, 4'b1111, 4'b0000);
    check_victim("lock.tree_kept", 2'd0, 1'b0);

    // Set 12: multi-bit hit touches the lowest way (way 1)
    drive(1'b1, 6'd12, 4'b0110, 4'b1111, 4'b0000);
    chk("hitmulti.no_victim", 32'(bus.victim_valid), 32'd0);
    drive(1'b1, 6'd12, 4'b0000, 4'b1111, 4'b0000);
    check_victim("hitmulti.victim", 2'd2, 1'b0);

    // Set 20 gets non-zero state, then a flush with an access held pending
    drive(1'b1, 6'd20, 4'b0000, 4'b1111, 4'b0000);
    check_victim("preflush", 2'd0, 1'b0);
    @(negedge clk);
    bus.flush_req = 1'b1;
    bus.acc_valid = 1'b1;
    #1;
    chk("flush.ready_low", 32'(bus.acc_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("flush.busy_start", 32'(bus.flush_busy),   32'd1);
    chk("flush.no_accept",  32'(bus.victim_valid), 32'd0);
    busy_cycles = 1;
    ready_bad   = 0;
    for (int c = 0; c < 100 && bus.flush_busy; c++) begin
      @(negedge clk);
      bus.flush_req = (c == 10);
      #1;
      if (bus.acc_ready !== 1'b0) ready_bad++;
      @(posedge clk);
      #1;
      if (bus.victim_valid !== 1'b0) ready_bad++;
      if (bus.flush_busy) busy_cycles++;
    end
    chk("flush.busy_cycles",      32'(busy_cycles), 32'd64);
    chk("flush.blocked_accesses", 32'(ready_bad),   32'd0);
    chk("flush.ready_back",       32'(bus.acc_ready), 32'd1);
    @(posedge clk);
    #1;
    check_victim("flush.cleared", 2'd0, 1'b0);

    // Pseudo-random mode from reset: start at seed[1:0] = 1
    pulse_reset();
    bus.repl_mode = 1'b1;
    drive(1'b1, 6'd3, 4'b0000, 4'b1111, 4'b0000);
    check_victim("rand.seed", 2'd1, 1'b0);
    pulse_reset();
    drive(1'b1, 6'd3, 4'b0000, 4'b1111, 4'b0010);
    check_victim("rand.skip_locked", 2'd2, 1'b0);

    // Asynchronous reset drops a pending victim pulse
    bus.acc_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid.victim_valid", 32'(bus.victim_valid), 32'd0);
    chk("rst_mid.victim_id",    32'(bus.victim_id),    32'd0);
    rst_n = 1'b1;

    // Asynchronous reset in the middle of a flush sweep
    bus.repl_mode = 1'b0;
    @(negedge clk);
    bus.flush_req = 1'b1;
    @(negedge clk);
    bus.flush_req = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_flush.busy_before", 32'(bus.flush_busy), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_flush.busy",         32'(bus.flush_busy),   32'd0);
    chk("rst_flush.acc_ready",    32'(bus.acc_ready),    32'd1);
    chk("rst_flush.victim_valid", 32'(bus.victim_valid), 32'd0);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
